maj_tt_sweep_ctrl: RTL

MAJ_TT_SWEEP_CTRL -- requirements
Module: maj_tt_sweep_ctrl

---
 rtl/maj_tt_sweep_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/maj_tt_sweep_ctrl.sv
// Truth-table sweep controller: walks x_out through all 128 minterms and captures f_in after EVAL_LAT cycles.
// Optional tt/tt_exp comparison compiled in with `define MAJ_TT_SWEEP_CMP_EN.
//
// state | meaning
// IDLE  | waiting for start; results held
// ISSUE | driving x_out = 0..127, one per cycle
// DRAIN | waiting for the delayed capture of index 127
// FIN   | done pulse, match update
module maj_tt_sweep_ctrl #(
    parameter int EVAL_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         f_in,
    input  logic [127:0] tt_exp,
    output logic [6:0]   x_out,
    output logic         busy,
    output logic         done,
    output logic [127:0] tt,
    output logic [7:0]   ones_cnt,
    output logic         match
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t       state_q, state_d;
    logic [6:0]   x_q, x_d;
    logic [127:0] tt_q, tt_d;
    logic [7:0]   ones_q, ones_d;
    logic         issue_v;
    logic         cap_v;
    logic [6:0]   cap_idx;

    assign issue_v = (state_q == ISSUE);

    generate
        if (EVAL_LAT == 0) begin : g_nodly
            assign cap_v   = issue_v;
            assign cap_idx = x_q;
        end else begin : g_dly
            logic [EVAL_LAT-1:0] vld_q;
            logic [6:0]          idx_q [EVAL_LAT];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < EVAL_LAT; i++) idx_q[i] <= '0;
                end else begin
                    vld_q[0] <= issue_v;
                    idx_q[0] <= x_q;
                    for (int i = 1; i < EVAL_LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        idx_q[i] <= idx_q[i-1];
                    end
                end
            end

            assign cap_v   = vld_q[EVAL_LAT-1];
            assign cap_idx = idx_q[EVAL_LAT-1];
        end
    endgenerate

`ifdef MAJ_TT_SWEEP_CMP_EN
    logic match_q, match_d;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        tt_d    = tt_q;
        ones_d  = ones_q;
`ifdef MAJ_TT_SWEEP_CMP_EN
        match_d = match_q;
`endif
        // Each index passes through the delay line exactly once, so no bit is rewritten
        if (cap_v) begin
            tt_d[cap_idx] = f_in;
            ones_d        = ones_q + {7'd0, f_in};
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    tt_d    = '0;
                    ones_d  = '0;
                    x_d     = '0;
                    state_d = ISSUE;
`ifdef MAJ_TT_SWEEP_CMP_EN
                    match_d = 1'b0;
`endif
                end
            end
            ISSUE: begin
                if (x_q == 7'd127) state_d = (EVAL_LAT == 0) ? FIN : DRAIN;
                else               x_d     = x_q + 7'd1;
            end
            DRAIN: begin
                if (cap_v && (cap_idx == 7'd127)) state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
`ifdef MAJ_TT_SWEEP_CMP_EN
                match_d = (tt_q == tt_exp);
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
`ifdef MAJ_TT_SWEEP_CMP_EN
            match_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
`ifdef MAJ_TT_SWEEP_CMP_EN
            match_q <= match_d;
`endif
        end
    end

    assign x_out    = x_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FIN);
    assign tt       = tt_q;
    assign ones_cnt = ones_q;

`ifdef MAJ_TT_SWEEP_CMP_EN
    assign match = match_q;
`else
    logic unused_tt_exp;
    assign unused_tt_exp = ^tt_exp;
    assign match         = 1'b0;
`endif

endmodule
